// File: rtl/pcs_rx_prbs31_checker_if.sv
// SERDES RX block bus (66-bit block plus valid) feeding the PRBS31 checker.
interface pcs_rx_prbs31_checker_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] serdes_rx_data;
  logic [HDR_WIDTH-1:0]  serdes_rx_hdr;
  logic                  serdes_rx_valid;

  modport master (output serdes_rx_data, serdes_rx_hdr, serdes_rx_valid);
  modport slave  (input  serdes_rx_data, serdes_rx_hdr, serdes_rx_valid);
endinterface

// File: rtl/pcs_rx_prbs31_checker.sv
// Self-synchronising PRBS31 (x^31 + x^28 + 1) checker for 66-bit RX blocks
// with per-block bit-error reporting, a saturating error counter and hunt/lock tracking.
module pcs_rx_prbs31_checker #(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_ERRORS = 16,
  parameter int UNLOCK_WINDOW = 1024,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst,
  pcs_rx_prbs31_checker_if.slave    serdes_rx,
  input  logic                      cfg_enable,
  input  logic                      cfg_clear_count,
  output logic                      pattern_lock,
  output logic                      block_error,
  output logic [6:0]                block_bit_errors,
  output logic                      block_checked,
  output logic [ERR_CNT_WIDTH-1:0]  error_count
);
  localparam int W       = DATA_WIDTH + HDR_WIDTH;
  localparam int CLEAN_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(UNLOCK_WINDOW + 1);
  localparam int ERRW    = $clog2(UNLOCK_ERRORS + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                   state_q, state_d;
  logic [30:0]              hist_q, hist_d;
  logic                     primed_q, primed_d;
  logic [CLEAN_W-1:0]       clean_q, clean_d;
  logic [WIN_W-1:0]         win_q, win_d;
  logic [ERRW-1:0]          errc_q, errc_d;
  logic                     blk_err_q, blk_err_d;
  logic                     blk_chk_q, blk_chk_d;
  logic [6:0]               bits_q, bits_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [W-1:0]             word;
  logic [W+30:0]            ext;
  logic [6:0]               popcnt;
  logic                     blk_bad;
  logic [CLEAN_W-1:0]       clean_inc;
  logic [ERR_CNT_WIDTH-1:0] cnt_base;
  logic [ERR_CNT_WIDTH+7:0] sum;

  // ext[30:0] is the previous 31 bits (ext[30] newest); bit j of the block
  // sits at ext[j+31], so its taps s[k-31], s[k-28] are ext[j], ext[j+3].
  always_comb begin
    word   = {serdes_rx.serdes_rx_data, serdes_rx.serdes_rx_hdr};
    ext    = {word, hist_q};
    popcnt = '0;
    for (int unsigned j = 0; j < W; j++) begin
      popcnt = popcnt + 7'(word[j] ^ ext[j] ^ ext[j+3]);
    end
    blk_bad   = (popcnt != '0);
    clean_inc = clean_q + 1'b1;
    cnt_base  = cfg_clear_count ? '0 : cnt_q;
    sum       = (ERR_CNT_WIDTH+8)'(cnt_base) + (ERR_CNT_WIDTH+8)'(popcnt);
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    primed_d  = primed_q;
    clean_d   = clean_q;
    win_d     = win_q;
    errc_d    = errc_q;
    blk_err_d = 1'b0;
    blk_chk_d = 1'b0;
    bits_d    = bits_q;
    cnt_d     = cnt_base;

    if (!cfg_enable) begin
      state_d  = HUNT;
      primed_d = 1'b0;
      clean_d  = '0;
      win_d    = '0;
      errc_d   = '0;
    end else if (serdes_rx.serdes_rx_valid) begin
      hist_d = word[W-1 -: 31];
      if (!primed_q) begin
        primed_d = 1'b1;
      end else begin
        blk_chk_d = 1'b1;
        blk_err_d = blk_bad;
        bits_d    = popcnt;
        cnt_d     = (sum[ERR_CNT_WIDTH+7:ERR_CNT_WIDTH] != '0) ? '1 : sum[ERR_CNT_WIDTH-1:0];
        unique case (state_q)
          HUNT: begin
            clean_d = blk_bad ? '0 : clean_inc;
            if (!blk_bad && clean_inc == CLEAN_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              clean_d = '0;
              win_d   = '0;
              errc_d  = '0;
            end
          end
          LOCKED: begin
            win_d  = win_q + 1'b1;
            errc_d = errc_q + ERRW'(blk_bad);
            // Loss of lock wins over a window rollover on the same block.
            if (errc_d == ERRW'(UNLOCK_ERRORS)) begin
              state_d = HUNT;
              clean_d = '0;
            end else if (win_d == WIN_W'(UNLOCK_WINDOW)) begin
              win_d  = '0;
              errc_d = '0;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      state_q   <= HUNT;
      hist_q    <= '0;
      primed_q  <= 1'b0;
      clean_q   <= '0;
      win_q     <= '0;
      errc_q    <= '0;
      blk_err_q <= 1'b0;
      blk_chk_q <= 1'b0;
      bits_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      primed_q  <= primed_d;
      clean_q   <= clean_d;
      win_q     <= win_d;
      errc_q    <= errc_d;
      blk_err_q <= blk_err_d;
      blk_chk_q <= blk_chk_d;
      bits_q    <= bits_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pattern_lock     = (state_q == LOCKED);
  assign block_error      = blk_err_q;
  assign block_checked    = blk_chk_q;
  assign block_bit_errors = bits_q;
  assign error_count      = cnt_q;
endmodule

// File: doc/pcs_rx_prbs31_checker.md
Name: pcs_rx_prbs31_checker

Overview:
- Receive-side PRBS31 test-pattern checker for the 10GBASE-R PCS loopback setup; the counterpart of the TX-side PRBS31 test-pattern generator.
- Sits on the SERDES RX interface in parallel with the eth_phy_10g RX path.
- Self-synchronises to a PRBS31 stream carried on the 66-bit blocks {serdes_rx_data, serdes_rx_hdr}, counts bit errors, and reports pattern lock through a hunt/lock state machine.

Parameters:
- DATA_WIDTH, 64, data bits per block (fixed at 64).
- HDR_WIDTH, 2, sync header bits per block (fixed at 2).
- LOCK_COUNT, 64, consecutive clean checked blocks needed for lock (range 1..1023).
- UNLOCK_ERRORS, 16, errored blocks within a window that force loss of lock.
- UNLOCK_WINDOW, 1024, length in checked blocks of the LOCKED-state error window.
- ERR_CNT_WIDTH, 16, width of the accumulated bit-error counter.

Ports:
- rx_clk  in  1  Single clock. All logic is on its rising edge.
- rx_rst  in  1  Synchronous, active-low reset.
- serdes_rx_data  in  DATA_WIDTH  Received block payload.
- serdes_rx_hdr  in  HDR_WIDTH  Received sync header.
- serdes_rx_valid  in  1  Block present this cycle.
- cfg_enable  in  1  Checker enable.
- cfg_clear_count  in  1  One-cycle pulse that clears error_count.
- pattern_lock  out  1  High in the LOCKED state.
- block_error  out  1  One-cycle pulse: the checked block had at least one mismatch.
- block_bit_errors  out  7  Mismatch count of the last checked block (0..66).
- block_checked  out  1  One-cycle pulse: a block was checked.
- error_count  out  ERR_CNT_WIDTH  Saturating sum of bit errors.

Behaviour:
- Bit order: stream word W = {serdes_rx_data, serdes_rx_hdr}. W[0] (hdr[0]) is the earliest bit and W[65] the latest.
- Pattern: PRBS31, x^31 + x^28 + 1, non-inverted.
  - Expected bit s[k] = s[k-31] XOR s[k-28], where s is the received stream.
  - Mismatch bit m[k] = received s[k] XOR expected s[k].
  - The 31-bit history register always loads the last 31 received bits, errored or not (self-synchronising).
- Priming:
  - After reset, or after cfg_enable goes low, the first valid block only loads the history register.
  - That block raises no block_checked and no errors.
  - A primed flag is set by it.
- Checking:
  - Each later valid block is checked.
  - block_bit_errors = popcount(m[65:0]).
  - Latency: inputs sampled at edge N give outputs at edge N+1.
  - With serdes_rx_valid low: the history register holds, the pulses stay low, block_bit_errors holds.
- error_count:
  - Adds block_bit_errors for each checked block and saturates at all-ones.
  - cfg_clear_count in the same cycle as an add: error_count takes that block's errors only.
  - Unaffected by cfg_enable.
- Lock FSM, two states. Only checked blocks advance the counters.
  - HUNT: clean_cnt increments on each clean block. An errored block sets clean_cnt to 0. On the block that makes clean_cnt equal LOCK_COUNT, go to LOCKED, set pattern_lock in that output cycle, and clear win_cnt and err_cnt.
  - LOCKED: win_cnt increments on every block. err_cnt increments on errored blocks.
    - If err_cnt reaches UNLOCK_ERRORS: go to HUNT and clear clean_cnt. This has priority over window expiry in the same cycle.
    - Otherwise, if win_cnt reaches UNLOCK_WINDOW: clear win_cnt and err_cnt and stay LOCKED.
- cfg_enable low:
  - State goes to HUNT. Primed flag, clean_cnt, win_cnt and err_cnt are cleared.
  - pattern_lock = 0. Pulses are suppressed.
  - block_bit_errors and error_count hold.
- Reset values (rx_rst = 0 at an edge): all outputs 0, state HUNT, all counters 0, history register 0, primed flag 0. Reset mid-block discards that block.

Test Plan:
- Clean PRBS31 stream, valid every cycle, cfg_enable = 1 -> first block primes only; block_checked from the 2nd block; pattern_lock rises at the output of the 65th valid block; error_count stays 0.
- Locked, flip W[0] of one block -> that block gives block_bit_errors = 3 (positions 0, 28, 31) and block_error pulses once; error_count = 3; lock held.
- Bitwise-inverted PRBS31 stream -> every checked block reports 66; with ERR_CNT_WIDTH = 8, error_count reaches 255 after 4 checked blocks and stays there; pattern_lock stays 0.
- Locked, 16 single-flip blocks within 1024 blocks -> pattern_lock falls on the output of the 16th errored block; then 64 clean blocks relock it.
- Locked, 15 errored blocks per 1024-block window over 3 windows -> pattern_lock stays 1; error_count = 135.
- cfg_clear_count coincident with a 3-error block -> error_count = 3. rx_rst low mid-stream -> all outputs 0 next edge; after release, re-priming is required and the first block yields no block_checked.
